// File: rtl/collect_2x1_buffered_seq_pkg.sv
// Shared constants for the 2x1 collect switch: command encodings and port indices.
package collect_2x1_buffered_seq_pkg;

    localparam logic [1:0] CMD_NA    = 2'b00;
    localparam logic [1:0] CMD_LOW   = 2'b01;
    localparam logic [1:0] CMD_HIGH  = 2'b10;
    localparam logic [1:0] CMD_MERGE = 2'b11;

    localparam int PORT_LOW  = 0;
    localparam int PORT_HIGH = 1;

endpackage

// File: rtl/collect_2x1_buffered_seq_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; absorbs downstream backpressure.
module sync_fifo_simple #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/collect_2x1_buffered_seq.sv
// Two-to-one collect switch: command-driven grant with round-robin merge, feeding an output FIFO.
module collect_2x1_buffered_seq
    import collect_2x1_buffered_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 2,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_valid,
    input  logic [2*DATA_WIDTH-1:0]  i_data_bus,
    output logic [1:0]               o_ready,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data_bus,
    input  logic                     i_ready,
    input  logic                     i_en,
    input  logic [COMMAND_WIDTH-1:0] i_cmd
);

    logic [1:0]            grant;
    logic                  can_accept;
    logic                  rr_ptr;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        grant = 2'b00;
        case (i_cmd)
            CMD_LOW:   grant[PORT_LOW]  = i_valid[PORT_LOW];
            CMD_HIGH:  grant[PORT_HIGH] = i_valid[PORT_HIGH];
            CMD_MERGE: begin
                if (&i_valid) grant[rr_ptr] = 1'b1;
                else          grant         = i_valid;
            end
            default:   grant = 2'b00;
        endcase
    end

    // Full blocks push even on a simultaneous pop so o_ready never sees i_ready.
    assign can_accept = i_en & ~fifo_full & ~rst;
    assign o_ready    = {2{can_accept}} & grant;
    assign push       = |o_ready;
    assign din        = o_ready[PORT_HIGH] ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                                           : i_data_bus[DATA_WIDTH-1:0];
    assign pop        = o_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (i_cmd == CMD_MERGE && push) begin
            rr_ptr <= ~o_ready[PORT_HIGH];
        end
    end

    sync_fifo_simple #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (din),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign o_valid    = ~fifo_empty;
    assign o_data_bus = o_valid ? head : '0;

endmodule

// File: doc/collect_2x1_buffered_seq.md
Name: collect_2x1_buffered_seq

Overview:
- Two-to-one collect switch. It is the merge counterpart of the 1x2 distribute switch in the PrimitiveSwitch library.
- It takes data from a low port and a high port and sends it on one output bus.
- Upstream and downstream both use a valid/ready handshake.
- A small output FIFO absorbs downstream backpressure, so no combinational path runs from downstream ready to upstream ready.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- COMMAND_WIDTH, 2, width of i_cmd.
- FIFO_DEPTH, 2, number of output buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_valid  input  2  per-port input valid; bit0 = low, bit1 = high.
- i_data_bus  input  2*DATA_WIDTH  {i_data_high, i_data_low}; low = [DATA_WIDTH-1:0].
- o_ready  output  2  per-port accept; a transfer occurs when i_valid[k] & o_ready[k].
- o_valid  output  1  output word valid.
- o_data_bus  output  DATA_WIDTH  output word; all zeros when o_valid = 0.
- i_ready  input  1  downstream accept; a pop occurs when o_valid & i_ready.
- i_en  input  1  switch enable; gates input acceptance only.
- i_cmd  input  COMMAND_WIDTH  00 = NA, 01 = Collect_low, 10 = Collect_high, 11 = Merge (round-robin).

Behaviour:
- Reset (asynchronous, rst = 1):
  - FIFO empty: o_valid = 0, o_data_bus = 0.
  - o_ready = 2'b00.
  - rr_ptr = 0 (low port has priority).
- can_accept = i_en & ~fifo_full & ~rst.
- Grant, combinational from i_cmd, i_valid and rr_ptr; at most one bit set:
  - 00: none.
  - 01: grant[0] = i_valid[0].
  - 10: grant[1] = i_valid[1].
  - 11, both valid: grant the port selected by rr_ptr.
  - 11, one valid: grant that port.
- o_ready[k] = can_accept & grant[k].
  - o_ready is never asserted for an invalid port.
  - o_ready never depends on i_ready.
- A granted word is pushed into the FIFO at the edge; latency is 1 cycle from accept to o_valid.
- rr_ptr updates only when i_cmd = 11 and a grant fires: rr_ptr <= ~granted_index.
  - It holds in every other case, including cmd 01/10 and i_en = 0.
- Output: o_valid = ~fifo_empty and o_data_bus = FIFO head.
  - The head is stable while o_valid & ~i_ready.
  - Order is strictly FIFO.
- Simultaneous push and pop:
  - Allowed in the same cycle; occupancy is unchanged.
  - When the FIFO is full, push is blocked even if a pop happens that cycle. This keeps o_ready independent of i_ready.
- Throughput: 1 word/cycle when i_ready is held high.
- i_en = 0: no new accepts. Words already in the FIFO keep draining.
- Changing i_cmd mid-stream takes effect the same cycle. Buffered words are unaffected.
- Reset mid-operation: buffered words are discarded and outputs return to reset values immediately.

Decomposition:
- Shared package: command encodings CMD_NA, CMD_LOW, CMD_HIGH, CMD_MERGE (2-bit) and port index constants.
- Sub-module sync_fifo_simple:
  - Parameters DATA_WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers of log2(DEPTH)+1 bits with wrap; asynchronous active-high reset.
- Top level holds the grant logic and rr_ptr.

Test Plan:
- Reset during traffic:
  - Stimulus: assert rst while the FIFO holds 2 words.
  - Required: same cycle, o_valid = 0, o_data_bus = 0, o_ready = 00. After release, the first merge grant goes to low.
- Collect_low:
  - Stimulus: cmd = 01, i_valid = 11, low = 0xA, high = 0xB, i_ready = 1.
  - Required: o_ready = 01; next cycle o_valid = 1 and o_data_bus = 0xA; high is never accepted.
- Merge alternation:
  - Stimulus: cmd = 11, both ports valid continuously, low = 0x1, high = 0x2, i_ready = 1.
  - Required: output sequence 0x1, 0x2, 0x1, 0x2, one word per cycle.
- Backpressure:
  - Stimulus: cmd = 10, high valid, i_ready = 0.
  - Required: after FIFO_DEPTH (2) accepts, o_ready = 00 and the head holds. Raising i_ready drains the words in order; o_ready reasserts the cycle after the first pop.
- Enable gating:
  - Stimulus: i_en = 0 with 1 word buffered, cmd = 11, both valid.
  - Required: o_ready = 00, the buffered word drains, rr_ptr is unchanged.
- NA command:
  - Stimulus: cmd = 00 with both ports valid.
  - Required: o_ready = 00 and o_valid stays 0.
